// File: rtl/mmcm_ps_responder.sv
// MMCM dynamic phase-shift port responder: emulates the ps_en -> ps_done
// handshake timing and tracks a saturating signed phase-step count.
module mmcm_ps_responder #(
  parameter int PHASE_WIDTH    = 32,
  parameter int PSDONE_LATENCY = 12,
  parameter int MAX_STEPS      = 280
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   ps_en,
  input  logic                   ps_inc_dec,
  output logic                   ps_done,
  output logic                   ps_busy,
  output logic [PHASE_WIDTH-1:0] phase,
  output logic                   sat_hit,
  output logic                   err_overlap
);

  localparam int CW =
    ($clog2(PSDONE_LATENCY) < 1) ? 1 : $clog2(PSDONE_LATENCY);

  localparam logic [CW-1:0] CNT_LOAD = CW'(PSDONE_LATENCY - 2);

  localparam logic signed [PHASE_WIDTH-1:0] P_MAX =
    PHASE_WIDTH'(MAX_STEPS);
  localparam logic signed [PHASE_WIDTH-1:0] P_MIN =
    -P_MAX;

  typedef enum logic {
    S_IDLE,
    S_WAIT
  } state_t;

  state_t state_q, state_n;

  logic [CW-1:0] cnt_q, cnt_n;
  logic          dir_q, dir_n;
  logic          busy_q, busy_n;
  logic          done_q, done_n;
  logic          sat_q, sat_n;
  logic          err_q, err_n;

  logic signed [PHASE_WIDTH-1:0] phase_q, phase_n;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      dir_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      sat_q   <= 1'b0;
      err_q   <= 1'b0;
      phase_q <= '0;
    end else begin
      state_q <= state_n;
      cnt_q   <= cnt_n;
      dir_q   <= dir_n;
      busy_q  <= busy_n;
      done_q  <= done_n;
      sat_q   <= sat_n;
      err_q   <= err_n;
      phase_q <= phase_n;
    end
  end

  always_comb begin
    state_n = state_q;
    cnt_n   = cnt_q;
    dir_n   = dir_q;
    busy_n  = busy_q;
    done_n  = 1'b0;
    sat_n   = 1'b0;
    err_n   = err_q;
    phase_n = phase_q;

    unique case (state_q)
      S_IDLE: begin
        if (ps_en) begin
          dir_n   = ps_inc_dec;
          cnt_n   = CNT_LOAD;
          busy_n  = 1'b1;
          state_n = S_WAIT;
        end
      end
      S_WAIT: begin
        // a request while busy is dropped but remembered as an error
        if (ps_en) begin
          err_n = 1'b1;
        end
        if (cnt_q != '0) begin
          cnt_n = cnt_q - CW'(1);
        end else begin
          done_n  = 1'b1;
          busy_n  = 1'b0;
          state_n = S_IDLE;
          if (dir_q) begin
            if (phase_q >= P_MAX) sat_n = 1'b1;
            else phase_n = phase_q + 1'b1;
          end else begin
            if (phase_q <= P_MIN) sat_n = 1'b1;
            else phase_n = phase_q - 1'b1;
          end
        end
      end
      default: begin
        state_n = S_IDLE;
      end
    endcase
  end

  assign ps_done     = done_q;
  assign ps_busy     = busy_q;
  assign phase       = phase_q;
  assign sat_hit     = sat_q;
  assign err_overlap = err_q;

endmodule
